ram_arbiter: RTL

Two-port arbiter and sequencer that shares the single-port, word-addressed data RAM between the instruction-fetch requester and the load/store requester. It grants one access at a time, drives the RAM's `write_enable`/`addr`/`data_in` and samples `data_out`. Each access is stretched to a programmable latency to model slower memory. Data accesses have priority, and a starvation counter bounds fetch stall.

---
 rtl/ram_arbiter_if.sv | 37 +++
 rtl/ram_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the single-port data RAM.
// Latency: none; plain wires.
// Backpressure: requesters hold req and payload until their ready pulse.
// Ports: fetch side (i_*), load/store side (d_*), RAM side (ram_*), busy status.
//   slave  : arbiter view (takes requests and RAM read data, drives the rest)
//   master : requester/RAM view (mirror image of slave)
interface ram_arbiter_if;
   // instruction-fetch requester
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_ready;
   // load/store requester
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ready;
   // single-port RAM
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   // status
   logic        busy;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
      output i_rdata, i_ready, d_rdata, d_ready, ram_we, ram_addr, ram_wdata, busy
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
      input  i_rdata, i_ready, d_rdata, d_ready, ram_we, ram_addr, ram_wdata, busy
   );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store; data wins
// unless fetch has been starved for STARVE_LIMIT consecutive data grants.
// Latency: request sampled in IDLE at cycle 0 -> ready + rdata in cycle LATENCY+1.
// Backpressure: one access in flight; pending requests wait (held by requester).
// Ports: clk, rst (sync, active high); bus = ram_arbiter_if.slave (fetch, data, RAM).
module ram_arbiter #(
   parameter int ADDR_LEN     = 16,
   parameter int LATENCY      = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic         clk,
   input  logic         rst,
   ram_arbiter_if.slave bus
);

   localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
   localparam int STV_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   // Addresses are forwarded untouched, so ADDR_LEN only has to be sane; an
   // unsupported parameter set shows up as this block in the elaborated tree.
   localparam bit PARAMS_OK = (ADDR_LEN >= 1) && (ADDR_LEN <= 30) &&
                              (LATENCY >= 1) && (STARVE_LIMIT >= 1);
   if (!PARAMS_OK) begin : g_unsupported_params
   end

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_RESP
   } state_t;

   typedef enum logic {
      OWN_I,
      OWN_D
   } owner_t;

   state_t            state;
   state_t            state_nxt;
   owner_t            owner;
   logic [CNT_W-1:0]  cnt;
   logic [STV_W-1:0]  starve_cnt;
   logic [31:0]       addr_q;
   logic [31:0]       wdata_q;
   logic              we_q;
   logic [31:0]       i_rdata_q;
   logic [31:0]       d_rdata_q;

   logic              grant_i;
   logic              grant_d;
   logic              starve_full;
   logic              access_last;

   assign starve_full = (starve_cnt == STV_W'(STARVE_LIMIT));
   assign access_last = (state == ST_ACCESS) && (cnt == '0);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_i   = 1'b0;
      grant_d   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            // Data has priority except when fetch has waited STARVE_LIMIT grants.
            if (bus.d_req && !(bus.i_req && starve_full)) begin
               grant_d = 1'b1;
            end else if (bus.i_req) begin
               grant_i = 1'b1;
            end
            if (grant_i || grant_d) begin
               state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt == '0) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         owner      <= OWN_I;
         cnt        <= '0;
         starve_cnt <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (grant_i) begin
                  owner   <= OWN_I;
                  addr_q  <= bus.i_addr;
                  we_q    <= 1'b0;
                  wdata_q <= '0;
               end else if (grant_d) begin
                  owner   <= OWN_D;
                  addr_q  <= bus.d_addr;
                  we_q    <= bus.d_we;
                  wdata_q <= bus.d_wdata;
               end
               if (grant_i || grant_d) begin
                  cnt <= CNT_W'(LATENCY - 1);
               end
               // Counts data grants that overtook a waiting fetch.
               if (grant_i || !bus.i_req) begin
                  starve_cnt <= '0;
               end else if (grant_d && !starve_full) begin
                  starve_cnt <= starve_cnt + 1'b1;
               end
            end
            ST_ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (owner == OWN_I) begin
                  i_rdata_q <= bus.ram_rdata;
               end else begin
                  // For a store this is the word as it was before the write edge.
                  d_rdata_q <= bus.ram_rdata;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   // The write strobe is confined to the final ACCESS cycle so a stretched
   // store writes the RAM exactly once.
   assign bus.ram_we    = access_last && we_q;
   assign bus.ram_addr  = (state == ST_ACCESS) ? addr_q  : '0;
   assign bus.ram_wdata = (state == ST_ACCESS) ? wdata_q : '0;

   assign bus.i_ready   = (state == ST_RESP) && (owner == OWN_I);
   assign bus.d_ready   = (state == ST_RESP) && (owner == OWN_D);
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.busy      = (state != ST_IDLE);

endmodule
